mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single LC-3b memory port between two requesters: the instruction-fetch side (I)
//  and the load/store data side (D), so fetch and LDR/STR logic issue requests independently.
//  Sits between the control/datapath and physical memory; speaks the mem_read/mem_write/
//  mem_resp protocol on both faces. Round-robin arbitration, one outstanding transaction.
// PARAMETERS
//  ADDR_W   16  address width
//  DATA_W   16  data width
//  MASK_W   2   byte-enable width (DATA_W/8)
// PORTS
//  clk              in   1       clock; all state updates on posedge
//  rst_n            in   1       asynchronous active-low reset
//  i_read           in   1       I-side read request, held until i_resp
//  i_addr           in   ADDR_W  I-side address
//  i_rdata          out  DATA_W  I-side read data (valid when i_resp=1)
//  i_resp           out  1       I-side completion, 1 cycle
//  d_read           in   1       D-side read request, held until d_resp
//  d_write          in   1       D-side write request, held until d_resp
//  d_addr           in   ADDR_W  D-side address
//  d_wdata          in   DATA_W  D-side write data
//  d_byte_enable    in   MASK_W  D-side write byte mask
//  d_rdata          out  DATA_W  D-side read data (valid when d_resp=1)
//  d_resp           out  1       D-side completion, 1 cycle
//  mem_read         out  1       memory read strobe
//  mem_write        out  1       memory write strobe
//  mem_address      out  ADDR_W  memory address
//  mem_wdata        out  DATA_W  memory write data
//  mem_byte_enable  out  MASK_W  memory byte mask
//  mem_rdata        in   DATA_W  memory read data
//  mem_resp         in   1       memory completion
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, last_grant=D; mem_read=mem_write=0, i_resp=d_resp=0,
//    mem_address=0, mem_wdata=0, mem_byte_enable=all-ones. Reset mid-transaction abandons it.
//  - States: IDLE, SERVE_I, SERVE_D (registered). last_grant flop records last served side.
//  - IDLE: I only pending -> SERVE_I; D only (d_read|d_write) -> SERVE_D; both -> side !=
//    last_grant; none -> stay. No memory strobes in IDLE. Grant latency: request seen at edge
//    N, strobe asserted in cycle N+1.
//  - SERVE_I: mem_read=i_read, mem_write=0, mem_address=i_addr, mem_byte_enable=all-ones.
//  - SERVE_D: mem_write=d_write, mem_read=d_read&~d_write (both high: write wins, read
//    suppressed), mem_address=d_addr, mem_wdata=d_wdata, mem_byte_enable=d_byte_enable.
//  - mem_* outputs combinational from state + granted side's inputs; zero/all-ones otherwise.
//  - Response: i_resp=mem_resp&(state==SERVE_I); d_resp=mem_resp&(state==SERVE_D), same cycle
//    (no added latency). i_rdata=d_rdata=mem_rdata unconditionally.
//  - Exit: on mem_resp in SERVE_x -> IDLE, last_grant<=x. Mandatory IDLE cycle between
//    transactions lets requester drop request after resp; no back-to-back re-grant.
//  - Abort: granted side deasserts request without mem_resp -> IDLE, last_grant unchanged.
//  - mem_resp while IDLE: ignored, no resp forwarded. Non-granted side is never given resp
//    and its request is held pending (no loss, no starvation: alternates under contention).
// TESTING
//  1 Reset: rst_n=0 async mid-cycle -> all strobes/resps 0, mem_byte_enable=2'b11 immediately.
//  2 i_read=1,i_addr=16'h0040, mem_resp after 3 wait cycles, mem_rdata=16'h1234 -> mem_read
//    high cycles 1-4 at 16'h0040, i_resp=1 cycle 4 with i_rdata=16'h1234, IDLE cycle 5.
//  3 d_write=1,d_addr=16'h0102,d_wdata=16'hBEEF,d_byte_enable=2'b01 -> mem_write=1, mask 2'b01,
//    mem_read=0, d_resp only on mem_resp; i_resp stays 0.
//  4 After reset, i_read and d_read asserted same cycle, held -> I served first, then D, then
//    re-raise both -> I again (alternation I,D,I,D over 4 transactions).
//  5 mem_resp pulsed while IDLE -> i_resp=d_resp=0, state stays IDLE.
//  6 d_read and d_write both 1 -> mem_write=1, mem_read=0; rst_n low during SERVE_D wait ->
//    strobes drop asynchronously, next grant follows I-first after release.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Memory-port handshake bundle: read/write strobes, address, data, mask, resp.
// The master drives the request; the slave returns rdata and resp.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int MASK_W = 2
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] byte_enable;
    logic [DATA_W-1:0] rdata;
    logic              resp;

    modport master (
        output read, write, addr, wdata, byte_enable,
        input  rdata, resp
    );

    modport slave (
        input  read, write, addr, wdata, byte_enable,
        output rdata, resp
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one LC-3b memory port between fetch (I) and load/store (D).
// One outstanding transaction; an idle cycle always separates two grants.
module mem_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int MASK_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_port_arbiter_if.slave    i_port,
    mem_port_arbiter_if.slave    d_port,
    mem_port_arbiter_if.master   mem
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t state, state_nx;
    logic   last_d, last_d_nx;
    logic   i_req, d_req;

    assign i_req = i_port.read;
    assign d_req = d_port.read | d_port.write;

    assign i_port.rdata = mem.rdata;
    assign d_port.rdata = mem.rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            last_d <= 1'b1;
        end else begin
            state  <= state_nx;
            last_d <= last_d_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        last_d_nx       = last_d;
        mem.read        = 1'b0;
        mem.write       = 1'b0;
        mem.addr        = '0;
        mem.wdata       = '0;
        mem.byte_enable = '1;
        i_port.resp     = 1'b0;
        d_port.resp     = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_req && d_req)
                    state_nx = last_d ? SERVE_I : SERVE_D;
                else if (i_req)
                    state_nx = SERVE_I;
                else if (d_req)
                    state_nx = SERVE_D;
            end
            SERVE_I: begin
                mem.read    = i_port.read;
                mem.addr    = i_port.addr;
                i_port.resp = mem.resp;
                if (mem.resp) begin
                    state_nx  = IDLE;
                    last_d_nx = 1'b0;
                end else if (!i_req) begin
                    state_nx = IDLE;
                end
            end
            SERVE_D: begin
                // a simultaneous read+write is treated as a write
                mem.write       = d_port.write;
                mem.read        = d_port.read & ~d_port.write;
                mem.addr        = d_port.addr;
                mem.wdata       = d_port.wdata;
                mem.byte_enable = d_port.byte_enable;
                d_port.resp     = mem.resp;
                if (mem.resp) begin
                    state_nx  = IDLE;
                    last_d_nx = 1'b1;
                end else if (!d_req) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic,
// checked cycle by cycle against a transaction-level ownership model.
module tb_mem_port_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) i_port ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) d_port ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) mem ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_port (i_port),
        .d_port (d_port),
        .mem    (mem)
    );

    int n_assert = 0;
    int n_fail = 0;
    // owner: 0 = nobody, 1 = I side, 2 = D side; last: side served most recently
    int owner = 0;
    int last = 2;
    logic got_i, got_d;
    int order[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner = 0;
        last = 2;
    endtask

    task automatic check_outputs();
        logic er, ew, eir, edr;
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd;
        logic [MW-1:0] eb;
        er = 0; ew = 0; eir = 0; edr = 0;
        ea = '0; ewd = '0; eb = '1;
        if (owner == 1) begin
            er = i_port.read;
            ea = i_port.addr;
            eir = mem.resp;
        end else if (owner == 2) begin
            ew = d_port.write;
            er = d_port.read && !d_port.write;
            ea = d_port.addr;
            ewd = d_port.wdata;
            eb = d_port.byte_enable;
            edr = mem.resp;
        end
        chk("mem_read", mem.read, er);
        chk("mem_write", mem.write, ew);
        chk("mem_address", mem.addr, ea);
        chk("mem_wdata", mem.wdata, ewd);
        chk("mem_byte_enable", mem.byte_enable, eb);
        chk("i_resp", i_port.resp, eir);
        chk("d_resp", d_port.resp, edr);
        chk("i_rdata", i_port.rdata, mem.rdata);
        chk("d_rdata", d_port.rdata, mem.rdata);
    endtask

    task automatic advance();
        bit ir, dr;
        ir = i_port.read;
        dr = d_port.read | d_port.write;
        if (owner == 0) begin
            if (ir && dr) owner = (last == 1) ? 2 : 1;
            else if (ir) owner = 1;
            else if (dr) owner = 2;
        end else if (mem.resp) begin
            last = owner;
            owner = 0;
        end else if ((owner == 1 && !ir) || (owner == 2 && !dr)) begin
            owner = 0;
        end
    endtask

    // called just after a negedge with inputs already driven
    task automatic cycle();
        #1;
        if (!rst_n) model_reset();
        check_outputs();
        got_i = i_port.resp;
        got_d = d_port.resp;
        @(posedge clk);
        if (rst_n) advance();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_port.read = 0; i_port.write = 0; i_port.addr = '0;
        i_port.wdata = '0; i_port.byte_enable = '1;
        d_port.read = 0; d_port.write = 0; d_port.addr = '0;
        d_port.wdata = '0; d_port.byte_enable = '1;
        mem.resp = 0; mem.rdata = '0;
    endtask

    initial begin
        bit i_pend, d_pend;
        int k;
        idle_inputs();
        @(negedge clk);

        // reset state
        cycle();
        chk("rst_be", mem.byte_enable, 2'b11);
        chk("rst_read", mem.read, 1'b0);
        rst_n = 1;

        // single I read, three wait states
        i_port.read = 1; i_port.addr = 16'h0040;
        cycle();
        for (int c = 1; c <= 4; c++) begin
            mem.resp = (c == 4);
            mem.rdata = 16'h1234;
            #1;
            chk("t2_read", mem.read, 1'b1);
            chk("t2_addr", mem.addr, 16'h0040);
            chk("t2_iresp", i_port.resp, (c == 4));
            if (c == 4) chk("t2_rdata", i_port.rdata, 16'h1234);
            cycle();
        end
        mem.resp = 0; i_port.read = 0;
        #1 chk("t2_idle", mem.read, 1'b0);
        cycle();

        // D write with partial mask
        d_port.write = 1; d_port.addr = 16'h0102;
        d_port.wdata = 16'hBEEF; d_port.byte_enable = 2'b01;
        cycle();
        for (int c = 1; c <= 3; c++) begin
            mem.resp = (c == 3);
            #1;
            chk("t3_write", mem.write, 1'b1);
            chk("t3_read", mem.read, 1'b0);
            chk("t3_mask", mem.byte_enable, 2'b01);
            chk("t3_wdata", mem.wdata, 16'hBEEF);
            chk("t3_dresp", d_port.resp, (c == 3));
            chk("t3_iresp", i_port.resp, 1'b0);
            cycle();
        end
        mem.resp = 0; d_port.write = 0;
        cycle();

        // contention after reset: alternation I, D, I, D
        rst_n = 0;
        cycle();
        rst_n = 1;
        i_port.read = 1; i_port.addr = 16'h0200;
        d_port.read = 1; d_port.addr = 16'h0300;
        order.delete();
        k = 0;
        while (order.size() < 4 && k < 40) begin
            #1 mem.resp = mem.read | mem.write;
            cycle();
            if (got_i) order.push_back(1);
            if (got_d) order.push_back(2);
            k++;
        end
        chk("t4_count", order.size(), 4);
        for (int n = 0; n < order.size() && n < 4; n++)
            chk("t4_order", order[n], (n % 2 == 0) ? 1 : 2);
        idle_inputs();
        cycle();

        // mem_resp while idle is ignored
        mem.resp = 1;
        #1;
        chk("t5_iresp", i_port.resp, 1'b0);
        chk("t5_dresp", d_port.resp, 1'b0);
        cycle();
        mem.resp = 0;
        #1 chk("t5_still_idle", mem.read | mem.write, 1'b0);
        cycle();

        // read+write together, then async reset during the wait
        d_port.read = 1; d_port.write = 1; d_port.addr = 16'h0500;
        d_port.byte_enable = 2'b10;
        cycle();
        #1;
        chk("t6_write", mem.write, 1'b1);
        chk("t6_read", mem.read, 1'b0);
        #1 rst_n = 0;
        model_reset();
        #1;
        chk("t6_rst_write", mem.write, 1'b0);
        chk("t6_rst_be", mem.byte_enable, 2'b11);
        check_outputs();
        @(negedge clk);
        rst_n = 1;
        i_port.read = 1; i_port.addr = 16'h0600;
        cycle();
        #1 chk("t6_i_first", mem.read & ~mem.write, 1'b1);
        chk("t6_addr", mem.addr, 16'h0600);
        cycle();
        idle_inputs();
        cycle();

        // random traffic against the model
        i_pend = 0; d_pend = 0;
        for (int n = 0; n < 800; n++) begin
            if (i_pend && (got_i || $urandom_range(0, 24) == 0)) begin
                i_pend = 0;
                i_port.read = 0;
            end
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1;
                i_port.read = 1;
                i_port.addr = AW'($urandom);
            end
            if (d_pend && (got_d || $urandom_range(0, 24) == 0)) begin
                d_pend = 0;
                d_port.read = 0; d_port.write = 0;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1;
                k = $urandom_range(0, 2);
                d_port.read = (k != 1);
                d_port.write = (k != 0);
                d_port.addr = AW'($urandom);
                d_port.wdata = DW'($urandom);
                d_port.byte_enable = MW'($urandom_range(1, 3));
            end
            mem.resp = ($urandom_range(0, 2) == 0);
            mem.rdata = DW'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
